// File: rtl/dmem_mmio_bridge.sv
// Data-memory slave bridge: routes CPU requests to a word BRAM with fixed read
// latency or to per-channel RX/TX stream FIFOs exposed as MMIO registers.
module dmem_mmio_bridge #(
  parameter int          DATA_W     = 32,
  parameter int          BRAM_AW    = 16,
  parameter int          RD_LAT     = 1,
  parameter int          N_CH       = 2,
  parameter int          CH_W       = 8,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   en,
  input  logic                   we,
  input  logic [31:0]            addr,
  input  logic [DATA_W-1:0]      wd,
  output logic                   stall,
  output logic [DATA_W-1:0]      rd,
  output logic                   bram_en,
  output logic                   bram_we,
  output logic [BRAM_AW-1:0]     bram_addr,
  output logic [DATA_W-1:0]      bram_wd,
  input  logic [DATA_W-1:0]      bram_rd,
  input  logic [N_CH*CH_W-1:0]   rx_data,
  input  logic [N_CH-1:0]        rx_valid,
  output logic [N_CH-1:0]        rx_ready,
  output logic [N_CH*CH_W-1:0]   tx_data,
  output logic [N_CH-1:0]        tx_valid,
  input  logic [N_CH-1:0]        tx_ready
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  localparam int         PW      = $clog2(FIFO_DEPTH);
  localparam logic [3:0] N_CH_L  = 4'(N_CH);

  logic [0:0] state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;

  logic              is_mmio, ch_ok;
  logic [29:0]       word_off;
  logic [2:0]        ch_sel;
  logic [1:0]        reg_sel;

  logic [N_CH-1:0]   rx_empty, rx_full, tx_empty, tx_full, rx_pop, tx_push;
  logic [CH_W-1:0]   rx_head [N_CH];

  logic              sel_rx_empty, sel_rx_full, sel_tx_empty, sel_tx_full;
  logic [CH_W-1:0]   sel_rx_head;
  logic              do_pop, do_push;
  logic              stall_c, bram_en_c, bram_we_c;
  logic [DATA_W-1:0] rd_c;

  // Word-granular offset keeps addr[1:0] out of the register decode.
  assign is_mmio  = (addr >= MMIO_BASE);
  assign word_off = addr[31:2] - MMIO_BASE[31:2];
  assign ch_sel   = word_off[4:2];
  assign reg_sel  = word_off[1:0];
  assign ch_ok    = is_mmio && (word_off[29:5] == '0) && ({1'b0, ch_sel} < N_CH_L);

  assign bram_addr = addr[BRAM_AW+1:2];
  assign bram_wd   = wd;

  always_comb begin
    sel_rx_empty = 1'b1;
    sel_rx_full  = 1'b0;
    sel_tx_empty = 1'b1;
    sel_tx_full  = 1'b0;
    sel_rx_head  = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_sel == 3'(c)) begin
        sel_rx_empty = rx_empty[c];
        sel_rx_full  = rx_full[c];
        sel_tx_empty = tx_empty[c];
        sel_tx_full  = tx_full[c];
        sel_rx_head  = rx_head[c];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_c    = 1'b0;
    rd_c       = '0;
    bram_en_c  = 1'b0;
    bram_we_c  = 1'b0;
    do_pop     = 1'b0;
    do_push    = 1'b0;
    if (state_reg == ST_WAIT) begin
      cnt_next = cnt_reg - 3'd1;
      if (cnt_reg == 3'd1) begin
        rd_c       = bram_rd;
        state_next = ST_IDLE;
      end else begin
        stall_c = 1'b1;
      end
    end else if (en) begin
      if (!is_mmio) begin
        bram_en_c = 1'b1;
        if (we) begin
          bram_we_c = 1'b1;
        end else begin
          stall_c    = 1'b1;
          state_next = ST_WAIT;
          cnt_next   = 3'(RD_LAT);
        end
      end else if (ch_ok) begin
        case (reg_sel)
          2'd0: if (!we && !sel_rx_empty) begin
            rd_c   = DATA_W'(sel_rx_head);
            do_pop = 1'b1;
          end
          2'd1: if (!we) rd_c[1:0] = {sel_rx_full, !sel_rx_empty};
          // TX push waits on the registered full flag only.
          2'd2: if (we) begin
            if (sel_tx_full) stall_c = 1'b1;
            else             do_push = 1'b1;
          end
          default: if (!we) rd_c[1:0] = {sel_tx_empty, !sel_tx_full};
        endcase
      end
    end
  end

  // Outputs are forced quiet while reset is held, even if the master keeps en high.
  assign stall   = stall_c   & nrst;
  assign bram_en = bram_en_c & nrst;
  assign bram_we = bram_we_c & nrst;
  assign rd      = nrst ? rd_c : '0;

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      rx_pop[c]  = do_pop  && (ch_sel == 3'(c));
      tx_push[c] = do_push && (ch_sel == 3'(c));
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CH_W-1:0] rx_mem [FIFO_DEPTH];
      logic [CH_W-1:0] tx_mem [FIFO_DEPTH];
      logic [PW:0]     rx_wr_reg, rx_rd_reg, tx_wr_reg, tx_rd_reg;
      logic            rx_push, tx_drain;

      assign rx_empty[gi] = (rx_wr_reg == rx_rd_reg);
      assign rx_full[gi]  = (rx_wr_reg[PW] != rx_rd_reg[PW]) &&
                            (rx_wr_reg[PW-1:0] == rx_rd_reg[PW-1:0]);
      assign tx_empty[gi] = (tx_wr_reg == tx_rd_reg);
      assign tx_full[gi]  = (tx_wr_reg[PW] != tx_rd_reg[PW]) &&
                            (tx_wr_reg[PW-1:0] == tx_rd_reg[PW-1:0]);

      assign rx_ready[gi] = !rx_full[gi];
      assign tx_valid[gi] = !tx_empty[gi];
      assign rx_push      = rx_valid[gi] && !rx_full[gi];
      assign tx_drain     = tx_valid[gi] && tx_ready[gi];

      assign rx_head[gi]                 = rx_mem[rx_rd_reg[PW-1:0]];
      assign tx_data[gi*CH_W +: CH_W]    = tx_mem[tx_rd_reg[PW-1:0]];

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          rx_wr_reg <= '0;
          rx_rd_reg <= '0;
          tx_wr_reg <= '0;
          tx_rd_reg <= '0;
        end else begin
          if (rx_push)     rx_wr_reg <= rx_wr_reg + 1'b1;
          if (rx_pop[gi])  rx_rd_reg <= rx_rd_reg + 1'b1;
          if (tx_push[gi]) tx_wr_reg <= tx_wr_reg + 1'b1;
          if (tx_drain)    tx_rd_reg <= tx_rd_reg + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rx_push)     rx_mem[rx_wr_reg[PW-1:0]] <= rx_data[gi*CH_W +: CH_W];
        if (tx_push[gi]) tx_mem[tx_wr_reg[PW-1:0]] <= wd[CH_W-1:0];
      end
    end
  endgenerate

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Directed bench for dmem_mmio_bridge: BRAM latency, RX/TX FIFOs, MMIO decode, reset abort.
module tb_dmem_mmio_bridge;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en, we;
  logic [31:0] addr, wd;
  logic        stall;
  logic [31:0] rd;
  logic        bram_en, bram_we;
  logic [15:0] bram_addr;
  logic [31:0] bram_wd, bram_rd;
  logic [15:0] rx_data, tx_data;
  logic [1:0]  rx_valid, rx_ready, tx_valid, tx_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_mmio_bridge #(
    .DATA_W(32), .BRAM_AW(16), .RD_LAT(LAT), .N_CH(2), .CH_W(8),
    .FIFO_DEPTH(8), .MMIO_BASE(32'hFFFF_FF00)
  ) u_dut (
    .clk(clk), .nrst(nrst), .en(en), .we(we), .addr(addr), .wd(wd),
    .stall(stall), .rd(rd), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_wd(bram_wd), .bram_rd(bram_rd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  // BRAM model: registered read followed by LAT-1 extra pipeline stages.
  logic [31:0] bmem [256];
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    if (bram_en && bram_we)  bmem[bram_addr[7:0]] <= bram_wd;
    if (bram_en && !bram_we) pipe[0] <= bmem[bram_addr[7:0]];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bram_rd = pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic e, input logic w, input logic [31:0] a, input logic [31:0] d);
    en = e; we = w; addr = a; wd = d;
    #1;
    if (e) $display("req we=%0b addr=%h wd=%h -> stall=%0b rd=%h", w, a, d, stall, rd);
  endtask

  initial begin
    en = 1'b0; we = 1'b0; addr = '0; wd = '0;
    rx_data = '0; rx_valid = '0; tx_ready = '0;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rd", rd, 32'd0);
    chk("rst_bram_en", 32'(bram_en), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd3);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    tick(); tick();
    #2 nrst = 1'b1;
    tick();

    // BRAM write then read with latency LAT
    req(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    chk("wr_stall", 32'(stall), 32'd0);
    chk("wr_bram_en", 32'(bram_en), 32'd1);
    chk("wr_bram_we", 32'(bram_we), 32'd1);
    chk("wr_bram_addr", 32'(bram_addr), 32'h10);
    tick();
    req(1'b1, 1'b0, 32'h40, 32'h0);
    chk("rd_issue_stall", 32'(stall), 32'd1);
    chk("rd_issue_bram_en", 32'(bram_en), 32'd1);
    chk("rd_issue_bram_we", 32'(bram_we), 32'd0);
    tick();
    for (int i = 0; i < LAT - 1; i++) begin
      chk("rd_wait_stall", 32'(stall), 32'd1);
      chk("rd_wait_bram_en", 32'(bram_en), 32'd0);
      tick();
    end
    chk("rd_done_stall", 32'(stall), 32'd0);
    chk("rd_done_data", rd, 32'hDEAD_BEEF);
    tick();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    chk("idle_rd", rd, 32'd0);

    // RX channel 1
    rx_data = 16'h4100; rx_valid = 2'b10;
    tick();
    rx_data = 16'h4200;
    tick();
    rx_valid = 2'b00;
    req(1'b1, 1'b0, 32'hFFFF_FF14, 32'h0);
    chk("rx1_stat_nonempty", rd, 32'd1);
    tick();
    req(1'b1, 1'b0, 32'hFFFF_FF10, 32'h0);
    chk("rx1_pop0", rd, 32'h41);
    chk("rx1_pop0_stall", 32'(stall), 32'd0);
    tick();
    req(1'b1, 1'b0, 32'hFFFF_FF10, 32'h0);
    chk("rx1_pop1", rd, 32'h42);
    tick();
    req(1'b1, 1'b0, 32'hFFFF_FF10, 32'h0);
    chk("rx1_pop_empty", rd, 32'h0);
    tick();
    req(1'b1, 1'b0, 32'hFFFF_FF14, 32'h0);
    chk("rx1_stat_empty", rd, 32'h0);
    tick();

    // TX channel 0 back-pressure
    req(1'b1, 1'b0, 32'hFFFF_FF0C, 32'h0);
    chk("tx0_stat_empty", rd, 32'd3);
    tick();
    for (int i = 0; i < 8; i++) begin
      req(1'b1, 1'b1, 32'hFFFF_FF08, 32'(8'h10 + 8'(i)));
      chk("tx0_push_stall", 32'(stall), 32'd0);
      tick();
    end
    req(1'b0, 1'b0, 32'h0, 32'h0);
    chk("tx0_valid", 32'(tx_valid), 32'd1);
    chk("tx0_head", 32'(tx_data[7:0]), 32'h10);
    req(1'b1, 1'b0, 32'hFFFF_FF0C, 32'h0);
    chk("tx0_stat_full", rd, 32'd0);
    tick();
    req(1'b1, 1'b1, 32'hFFFF_FF08, 32'h18);
    chk("tx0_full_stall0", 32'(stall), 32'd1);
    tick();
    #1;
    chk("tx0_full_stall1", 32'(stall), 32'd1);
    tx_ready = 2'b01;
    #1;
    chk("tx0_drain_cycle_stall", 32'(stall), 32'd1);
    tick();
    tx_ready = 2'b00;
    #1;
    chk("tx0_push_after_drain", 32'(stall), 32'd0);
    chk("tx0_head_after_drain", 32'(tx_data[7:0]), 32'h11);
    tick();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    tx_ready = 2'b01;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("tx0_drain_valid", 32'(tx_valid[0]), 32'd1);
      chk("tx0_drain_data", 32'(tx_data[7:0]), 32'(8'h11 + 8'(i)));
      tick();
    end
    tx_ready = 2'b00;
    #1;
    chk("tx0_drained", 32'(tx_valid), 32'd0);

    // RX channel 0 fill to full, then simultaneous push/pop
    rx_valid = 2'b01;
    for (int i = 0; i < 10; i++) begin
      rx_data = {8'h00, 8'hA0 + 8'(i)};
      #1;
      chk("rx0_ready", 32'(rx_ready[0]), 32'(i < 8));
      tick();
    end
    rx_valid = 2'b00;
    req(1'b1, 1'b0, 32'hFFFF_FF04, 32'h0);
    chk("rx0_stat_full", rd, 32'd3);
    tick();
    for (int i = 0; i < 3; i++) begin
      req(1'b1, 1'b0, 32'hFFFF_FF00, 32'h0);
      chk("rx0_pop", rd, 32'(8'hA0 + 8'(i)));
      tick();
    end
    rx_valid = 2'b01; rx_data = 16'h00B0;
    req(1'b1, 1'b0, 32'hFFFF_FF00, 32'h0);
    chk("rx0_pop_push", rd, 32'hA3);
    tick();
    rx_valid = 2'b00;
    for (int i = 0; i < 5; i++) begin
      req(1'b1, 1'b0, 32'hFFFF_FF00, 32'h0);
      chk("rx0_order", rd, (i < 4) ? 32'(8'hA4 + 8'(i)) : 32'hB0);
      tick();
    end
    req(1'b1, 1'b0, 32'hFFFF_FF00, 32'h0);
    chk("rx0_empty_after", rd, 32'h0);
    tick();
    rx_valid = 2'b01; rx_data = 16'h00C5;
    req(1'b1, 1'b0, 32'hFFFF_FF00, 32'h0);
    chk("rx0_read_while_push_empty", rd, 32'h0);
    tick();
    rx_valid = 2'b00;
    req(1'b1, 1'b0, 32'hFFFF_FF00, 32'h0);
    chk("rx0_pushed_during_read", rd, 32'hC5);
    tick();

    // Out-of-range accesses leave FIFOs untouched
    rx_data = 16'h5500; rx_valid = 2'b10;
    tick();
    rx_valid = 2'b00;
    req(1'b1, 1'b0, 32'hFFFF_FF70, 32'h0);
    chk("oor_read_rd", rd, 32'h0);
    chk("oor_read_stall", 32'(stall), 32'd0);
    tick();
    req(1'b1, 1'b1, 32'hFFFF_FF70, 32'h33);
    chk("oor_write_stall", 32'(stall), 32'd0);
    tick();
    req(1'b1, 1'b1, 32'hFFFF_FF10, 32'h99);
    chk("wr_rxdata_stall", 32'(stall), 32'd0);
    tick();
    req(1'b1, 1'b0, 32'hFFFF_FF08, 32'h0);
    chk("rd_txdata_rd", rd, 32'h0);
    tick();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    chk("oor_no_tx", 32'(tx_valid), 32'd0);
    req(1'b1, 1'b0, 32'hFFFF_FF14, 32'h0);
    chk("oor_rx1_stat", rd, 32'd1);
    tick();
    req(1'b1, 1'b0, 32'hFFFF_FF10, 32'h0);
    chk("oor_rx1_data", rd, 32'h55);
    tick();

    // Reset during WAIT aborts the read and clears FIFOs
    req(1'b1, 1'b1, 32'hFFFF_FF08, 32'h77);
    tick();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    chk("pre_rst_tx_valid", 32'(tx_valid), 32'd1);
    req(1'b1, 1'b0, 32'h40, 32'h0);
    chk("abort_issue_stall", 32'(stall), 32'd1);
    tick();
    #1;
    chk("abort_wait_stall", 32'(stall), 32'd1);
    nrst = 1'b0;
    #1;
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_rd", rd, 32'h0);
    chk("abort_bram_en", 32'(bram_en), 32'd0);
    chk("abort_tx_valid", 32'(tx_valid), 32'd0);
    chk("abort_rx_ready", 32'(rx_ready), 32'd3);
    tick();
    nrst = 1'b1;
    #1;
    chk("reissue_stall", 32'(stall), 32'd1);
    chk("reissue_bram_en", 32'(bram_en), 32'd1);
    tick();
    for (int i = 0; i < LAT - 1; i++) begin
      chk("reissue_wait_stall", 32'(stall), 32'd1);
      tick();
    end
    chk("reissue_done_stall", 32'(stall), 32'd0);
    chk("reissue_done_rd", rd, 32'hDEAD_BEEF);
    tick();
    req(1'b0, 1'b0, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_mmio_bridge.md
Name: dmem_mmio_bridge

Overview:
- Slave-side bridge for the CPU data-memory port.
- Decodes each request to either a word-addressed BRAM with parametrised read latency, or N_CH memory-mapped stream channels (UART-style). Each channel has its own RX and TX FIFOs.
- Generates stall for BRAM read latency and for TX back-pressure.
- Sits between the core's data-memory master and the BRAM and I/O endpoints.

Parameters:
- DATA_W, 32, data word width.
- BRAM_AW, 16, BRAM word-address width.
- RD_LAT, 1, BRAM read latency in cycles; legal range 1..4.
- N_CH, 2, number of MMIO stream channels; legal range 1..8.
- CH_W, 8, stream data width per channel; must be ≤ DATA_W.
- FIFO_DEPTH, 8, entries per RX and per TX FIFO; power of 2, ≥ 2.
- MMIO_BASE, 32'hFFFF_FF00, byte addresses ≥ MMIO_BASE are MMIO; all lower addresses are BRAM.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- en  in  1  request valid
- we  in  1  1 = write, 0 = read
- addr  in  32  byte address; addr[1:0] ignored
- wd  in  DATA_W  write data
- stall  out  1  request not yet complete; master holds en/we/addr/wd stable while high
- rd  out  DATA_W  read data, valid in the completion cycle
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  BRAM_AW  equals addr[BRAM_AW+1:2]
- bram_wd  out  DATA_W  BRAM write data
- bram_rd  in  DATA_W  BRAM read data, RD_LAT cycles after issue
- rx_data  in  N_CH*CH_W  inbound stream data, channel c at [c*CH_W +: CH_W]
- rx_valid  in  N_CH  inbound valid
- rx_ready  out  N_CH  equals !rx_full[c]
- tx_data  out  N_CH*CH_W  outbound data; FIFO head
- tx_valid  out  N_CH  equals !tx_empty[c]
- tx_ready  in  N_CH  outbound ready

Behaviour:
- Clock and reset: one clock, clk. nrst is asynchronous, active-low.
- Reset values: FSM IDLE; latency counter 0; all FIFOs empty; stall=0; rd=0; bram_en=0; rx_ready=all 1; tx_valid=0.
- Completion: a request completes in the cycle where en=1 and stall=0. When no read completes, rd=0.
- FSM state IDLE, BRAM write: bram_en=bram_we=1 that cycle; stall=0; completes the same cycle.
- FSM state IDLE, BRAM read: issue bram_en=1, bram_we=0; stall=1; load counter with RD_LAT; go to WAIT.
- FSM state WAIT: counter decrements each cycle; bram_en=0; stall=1 while counter≠1.
  - In the cycle counter==1: stall=0, rd=bram_rd; return to IDLE.
  - Net effect: stall is high for exactly RD_LAT cycles, and data completes in cycle t+RD_LAT.
- MMIO map: offset = addr − MMIO_BASE; channel c = offset[6:4]; register = offset[3:2].
  - 0: RX_DATA (R). Pops the RX FIFO; rd = zero-extended head. If the RX FIFO is empty: rd=0 and no pop.
  - 1: RX_STAT (R). rd[0] = !rx_empty; rd[1] = rx_full.
  - 2: TX_DATA (W). Pushes wd[CH_W-1:0]. If the TX FIFO is full: stall=1 until not full, then push and complete.
  - 3: TX_STAT (R). rd[0] = !tx_full; rd[1] = tx_empty.
  - Out-of-range: c ≥ N_CH, writes to R registers, or reads of TX_DATA all return rd=0, have no side effect, and do not stall.
- MMIO timing: MMIO reads are combinational, with zero wait states. A pop takes effect at the clock edge of the completion cycle.
- RX push: occurs when rx_valid[c] && rx_ready[c].
  - Simultaneous push and pop on a non-empty FIFO: both take effect; count unchanged.
  - Push into an empty FIFO while the CPU reads: the CPU read sees empty (rd=0, no pop); the push succeeds.
- TX drain: occurs when tx_valid[c] && tx_ready[c].
  - A CPU push stalls on the registered full flag, with no same-cycle bypass. A drain at full therefore frees a slot, and the push completes the following cycle.
- FIFO pointers: wrap modulo FIFO_DEPTH. Full/empty use an extra pointer bit.
- Reset mid-operation: nrst low in WAIT or during a TX stall aborts the request immediately. All state returns to reset values, and FIFO contents are discarded.
- en=0 in IDLE: no BRAM access and no FIFO side effect.

Test Plan:
- RD_LAT=3: write 0xDEADBEEF to 0x40, then read 0x40 → stall high exactly 3 cycles; in the 4th cycle stall=0 and rd=0xDEADBEEF. The write completes with stall=0.
- Channel 1: drive rx_valid with 0x41, 0x42; read 0xFFFF_FF10 twice → rd=0x41, then 0x42. A third read → rd=0, RX_STAT (0xFFFF_FF14) reads 0.
- Channel 0, tx_ready=0: write 9 bytes to 0xFFFF_FF08 → the 9th write stalls. Raise tx_ready for one cycle → stall drops the next cycle; tx_data emits 1st byte first.
- RX FIFO full (8 entries) with rx_valid held → rx_ready=0. Pop and push in the same cycle with count 5 → count stays 5 and order is preserved.
- Assert nrst during a WAIT cycle (RD_LAT=4) → stall=0 and rd=0 immediately; a subsequent read succeeds with the correct latency.
- Read 0xFFFF_FF70 with N_CH=2 → rd=0, no stall, no FIFO change.
